// File: rtl/fpu_add_pkg.sv
// Shared types and constants for the single-precision adder pipeline stages.
// Holds the add_step2 buffer entry layout and the rounding-mode encodings.
package fpu_add_pkg;

    localparam int FRAC_W = 26;
    localparam int SUM_W  = FRAC_W + 1;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;

    typedef struct packed {
        logic             sign;
        logic [SUM_W-1:0] sum;
        logic             zero;
        logic [7:0]       exp_max;
        logic [2:0]       frm;
    } add_step2_entry_t;

endpackage

// File: rtl/add_step2_mag.sv
// Combinational sign-magnitude adder for two aligned fractions.
// Exact cancellation yields +0, or -0 when rounding toward negative infinity.
module add_step2_mag #(
    parameter int FRAC_W = 26
) (
    input  logic              i_sign_a,
    input  logic [FRAC_W-1:0] i_frac_a,
    input  logic              i_sign_b,
    input  logic [FRAC_W-1:0] i_frac_b,
    input  logic [2:0]        i_frm,
    output logic              o_sign,
    output logic [FRAC_W:0]   o_sum,
    output logic              o_zero
);
    import fpu_add_pkg::*;

    // NOTE: every output of an always_comb gets a default first so no path
    // through the if/else chain can leave it unassigned and infer a latch.
    always_comb begin
        o_sign = i_sign_a;
        o_sum  = '0;
        if (i_sign_a == i_sign_b) begin
            o_sum = {1'b0, i_frac_a} + {1'b0, i_frac_b};
        end else if (i_frac_a > i_frac_b) begin
            o_sum = {1'b0, i_frac_a - i_frac_b};
        end else if (i_frac_b > i_frac_a) begin
            o_sum  = {1'b0, i_frac_b - i_frac_a};
            o_sign = i_sign_b;
        end else begin
            o_sign = (i_frm == RDN);
        end
    end

    assign o_zero = (o_sum == '0);

endmodule

// File: rtl/add_step2.sv
// FPU adder stage 2: sign-magnitude add feeding a DEPTH-entry valid/ready FIFO.
// Optional macro ADD_STEP2_STATS_EN adds a saturating exact-cancellation counter.
module add_step2 #(
    parameter int DEPTH  = 2,
    parameter int FRAC_W = 26
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_shifted,
    input  logic [FRAC_W-1:0] frac_shifted,
    input  logic              sign_not_shifted,
    input  logic [FRAC_W-1:0] frac_not_shifted,
    input  logic [7:0]        exp_max,
    input  logic [2:0]        frm_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [FRAC_W:0]   sum_out,
    output logic              carry_out,
    output logic              zero_out,
    output logic [7:0]        exp_max_out,
    output logic [2:0]        frm_out
`ifdef ADD_STEP2_STATS_EN
    ,
    output logic [15:0]       cancel_cnt
`endif
);
    import fpu_add_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic              w_sign;
    logic [FRAC_W:0]   w_sum;
    logic              w_zero;
    logic              w_push;
    logic              w_pop;
    add_step2_entry_t  w_new;

    add_step2_entry_t  r_mem [DEPTH];
    add_step2_entry_t  r_head;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    add_step2_mag #(.FRAC_W(FRAC_W)) u_mag (
        .i_sign_a (sign_shifted),
        .i_frac_a (frac_shifted),
        .i_sign_b (sign_not_shifted),
        .i_frac_b (frac_not_shifted),
        .i_frm    (frm_in),
        .o_sign   (w_sign),
        .o_sum    (w_sum),
        .o_zero   (w_zero)
    );

    assign w_new = '{sign: w_sign, sum: w_sum, zero: w_zero, exp_max: exp_max, frm: frm_in};

    assign in_ready  = (r_count < DEPTH_C);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order within the block.
    // NOTE: the entries are reset too, because reset must leave the buffer cleared.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_new;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // The head register mirrors the next FIFO head; it holds when the FIFO drains.
            if (w_push && (r_count == '0)) begin
                r_head <= w_new;
            end else if (w_pop) begin
                if (r_count > CNT_W'(1)) begin
                    r_head <= r_mem[r_rptr + PTR_W'(1)];
                end else if (w_push) begin
                    r_head <= w_new;
                end
            end
        end
    end

    assign sign_out    = r_head.sign;
    assign sum_out     = r_head.sum;
    assign carry_out   = r_head.sum[FRAC_W];
    assign zero_out    = r_head.zero;
    assign exp_max_out = r_head.exp_max;
    assign frm_out     = r_head.frm;

`ifdef ADD_STEP2_STATS_EN
    logic [15:0] r_cancel_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cancel_cnt <= '0;
        end else if (w_push && (sign_shifted != sign_not_shifted) && w_zero
                     && (r_cancel_cnt != 16'hFFFF)) begin
            r_cancel_cnt <= r_cancel_cnt + 16'd1;
        end
    end

    assign cancel_cnt = r_cancel_cnt;
`endif

endmodule

// File: tb/tb_add_step2.sv
// Directed testbench for add_step2 with hand-computed expected results.
// Covers reset, add/sub/cancel arithmetic, backpressure, streaming and async reset.
module tb_add_step2;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic        sign_shifted;
    logic [25:0] frac_shifted;
    logic        sign_not_shifted;
    logic [25:0] frac_not_shifted;
    logic [7:0]  exp_max;
    logic [2:0]  frm_in;
    logic        out_valid;
    logic        out_ready;
    logic        sign_out;
    logic [26:0] sum_out;
    logic        carry_out;
    logic        zero_out;
    logic [7:0]  exp_max_out;
    logic [2:0]  frm_out;
`ifdef ADD_STEP2_STATS_EN
    logic [15:0] cancel_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    add_step2 #(.DEPTH(2), .FRAC_W(26)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .sign_shifted     (sign_shifted),
        .frac_shifted     (frac_shifted),
        .sign_not_shifted (sign_not_shifted),
        .frac_not_shifted (frac_not_shifted),
        .exp_max          (exp_max),
        .frm_in           (frm_in),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .sign_out         (sign_out),
        .sum_out          (sum_out),
        .carry_out        (carry_out),
        .zero_out         (zero_out),
        .exp_max_out      (exp_max_out),
        .frm_out          (frm_out)
`ifdef ADD_STEP2_STATS_EN
        ,
        .cancel_cnt       (cancel_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_op(input logic ss, input logic [25:0] fs, input logic sn,
                          input logic [25:0] fn, input logic [7:0] e, input logic [2:0] frm);
        sign_shifted     = ss;
        frac_shifted     = fs;
        sign_not_shifted = sn;
        frac_not_shifted = fn;
        exp_max          = e;
        frm_in           = frm;
        in_valid         = 1'b1;
    endtask

    // Apply one operation for a single cycle, leaving results visible 1 cycle later.
    task automatic do_op(input logic ss, input logic [25:0] fs, input logic sn,
                         input logic [25:0] fn, input logic [7:0] e, input logic [2:0] frm);
        set_op(ss, fs, sn, fn, e, frm);
        tick();
        in_valid = 1'b0;
    endtask

    int accepted;

    initial begin
        RST = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sign_shifted = 1'b0;
        frac_shifted = '0;
        sign_not_shifted = 1'b0;
        frac_not_shifted = '0;
        exp_max = '0;
        frm_in = '0;
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_sum", 64'(sum_out), 64'h0);
        RST = 1'b0;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'h1);

        // Same-sign add with carry
        do_op(1'b0, 26'h2000000, 1'b0, 26'h2000000, 8'd127, 3'b000);
        check("add_valid", 64'(out_valid), 64'h1);
        check("add_sum", 64'(sum_out), 64'h4000000);
        check("add_carry", 64'(carry_out), 64'h1);
        check("add_sign", 64'(sign_out), 64'h0);
        check("add_exp", 64'(exp_max_out), 64'd127);
        check("add_zero", 64'(zero_out), 64'h0);

        // Subtraction, not-shifted operand larger
        do_op(1'b1, 26'h1000000, 1'b0, 26'h2000000, 8'd100, 3'b011);
        check("sub_sum", 64'(sum_out), 64'h1000000);
        check("sub_sign", 64'(sign_out), 64'h0);
        check("sub_carry", 64'(carry_out), 64'h0);
        check("sub_frm", 64'(frm_out), 64'h3);

        // Subtraction, shifted operand larger and negative
        do_op(1'b1, 26'h2000000, 1'b0, 26'h0800000, 8'd90, 3'b001);
        check("sub2_sum", 64'(sum_out), 64'h1800000);
        check("sub2_sign", 64'(sign_out), 64'h1);

        // Exact cancellation, RDN then RNE
        do_op(1'b1, 26'h2400000, 1'b0, 26'h2400000, 8'd50, 3'b010);
        check("cancel_rdn_sum", 64'(sum_out), 64'h0);
        check("cancel_rdn_zero", 64'(zero_out), 64'h1);
        check("cancel_rdn_sign", 64'(sign_out), 64'h1);
        do_op(1'b0, 26'h2400000, 1'b1, 26'h2400000, 8'd50, 3'b000);
        check("cancel_rne_zero", 64'(zero_out), 64'h1);
        check("cancel_rne_sign", 64'(sign_out), 64'h0);

        // Same-sign zeros keep the common sign
        do_op(1'b1, 26'h0, 1'b1, 26'h0, 8'd0, 3'b000);
        check("zero_same_zero", 64'(zero_out), 64'h1);
        check("zero_same_sign", 64'(sign_out), 64'h1);
`ifdef ADD_STEP2_STATS_EN
        check("cancel_cnt", 64'(cancel_cnt), 64'd2);
`endif
        tick();
        check("drain_valid", 64'(out_valid), 64'h0);

        // Backpressure: 3 offered, 2 accepted
        out_ready = 1'b0;
        accepted = 0;
        for (int k = 0; k < 3; k++) begin
            set_op(1'b0, 26'(k + 1), 1'b0, 26'(k + 1), 8'd10, 3'b000);
            if (k == 2) check("bp_in_ready_full", 64'(in_ready), 64'h0);
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted", 64'(accepted), 64'd2);
        check("bp_head_sum", 64'(sum_out), 64'd2);
        out_ready = 1'b1;
        tick();
        check("bp_in_ready_after_pop", 64'(in_ready), 64'h1);
        check("bp_second_sum", 64'(sum_out), 64'd4);
        tick();
        check("bp_empty", 64'(out_valid), 64'h0);
        check("bp_hold_sum", 64'(sum_out), 64'd4);

        // Streaming: 10 back-to-back operations
        for (int i = 0; i < 10; i++) begin
            set_op(1'b0, 26'(3 * i + 5), 1'b0, 26'(i), 8'(i), 3'b000);
            tick();
            check("stream_valid", 64'(out_valid), 64'h1);
            check("stream_sum", 64'(sum_out), 64'(4 * i + 5));
            check("stream_in_ready", 64'(in_ready), 64'h1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_valid", 64'(out_valid), 64'h0);

        // Reset mid-operation with two buffered entries
        out_ready = 1'b0;
        do_op(1'b0, 26'h0000011, 1'b0, 26'h0000022, 8'd77, 3'b100);
        do_op(1'b0, 26'h0000001, 1'b0, 26'h0000001, 8'd78, 3'b100);
        check("mid_full", 64'(in_ready), 64'h0);
        #2;
        RST = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'h0);
        check("mid_rst_sum", 64'(sum_out), 64'h0);
        check("mid_rst_exp", 64'(exp_max_out), 64'h0);
        check("mid_rst_frm", 64'(frm_out), 64'h0);
        tick();
        RST = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'h1);
        check("post_rst_valid", 64'(out_valid), 64'h0);
        do_op(1'b0, 26'h0000010, 1'b1, 26'h0000030, 8'd5, 3'b000);
        check("post_rst_sum", 64'(sum_out), 64'h20);
        check("post_rst_sign", 64'(sign_out), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/add_step2.md
Name: add_step2

Overview:
- Second stage of the FPU single-precision adder.
- Consumes the aligned operands produced by the alignment stage (ADD_step1): the shifted and non-shifted 26-bit fractions, their signs, exp_max and the rounding mode.
- Performs the sign-magnitude add/subtract, holds results in a 2-entry output buffer with valid/ready handshakes, and feeds the normalisation/rounding stage.

Parameters:
- DEPTH, 2, output buffer entries; legal values 2 or 4.
- FRAC_W, 26, aligned fraction width (hidden bit at bit 25, two guard bits at [1:0]).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream operands valid.
- in_ready  out  1  stage can accept operands.
- sign_shifted  in  1  sign of the aligned (shifted) operand.
- frac_shifted  in  FRAC_W  aligned fraction.
- sign_not_shifted  in  1  sign of the larger-exponent operand.
- frac_not_shifted  in  FRAC_W  fraction of the larger-exponent operand.
- exp_max  in  8  larger exponent.
- frm_in  in  3  rounding mode.
- out_valid  out  1  result available at buffer head.
- out_ready  in  1  downstream accepts the result.
- sign_out  out  1  result sign.
- sum_out  out  FRAC_W+1  result magnitude; bit FRAC_W is the carry.
- carry_out  out  1  equals sum_out[FRAC_W]; tells the next stage to right-shift by 1.
- zero_out  out  1  magnitude is exactly zero.
- exp_max_out  out  8  exp_max passed through.
- frm_out  out  3  frm_in passed through.

Behaviour:
- Arithmetic is combinational on the inputs; the result is written into the buffer on accept (in_valid && in_ready).
- Equal signs: sum = frac_shifted + frac_not_shifted, zero-extended to FRAC_W+1; sign = common sign.
- Different signs:
  - sum = larger minus smaller magnitude; sign = sign of the larger magnitude.
  - Magnitudes equal: sum = 0, zero_out = 1, sign = 1 only when frm_in == 3'b010 (RDN), else 0.
- Equal-sign case with both fractions zero: sum = 0, zero_out = 1, sign = common sign.
- Buffer is a FIFO with wrapping read/write pointers and a count register.
  - in_ready = (count < DEPTH); does not depend combinationally on out_ready.
  - out_valid = (count != 0).
  - Outputs present the head entry, registered with no combinational path from inputs.
- Latency: 1 cycle from accept to out_valid when the buffer is empty.
- Throughput: 1 result per cycle while out_ready stays high.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full: in_ready = 0; a pop that cycle raises in_ready on the following cycle.
- Empty: out_ready is ignored; output data fields hold the last head value.
- Reset (any time, including mid-transfer):
  - count and pointers = 0, all entries cleared.
  - out_valid = 0; sign_out, sum_out, carry_out, zero_out, exp_max_out, frm_out = 0.
  - in_ready = 1 after reset deasserts.
- No state machine beyond the FIFO count; the buffer never overflows or underflows by construction.

Optional Feature:
- ADD_STEP2_STATS_EN defined:
  - Adds output cancel_cnt (16 bits), incremented on every accepted operation with different signs whose result is exactly zero.
  - Saturates at 16'hFFFF; cleared by RST.
- Macro undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package fpu_add_pkg holds:
  - FRAC_W and SUM_W localparams.
  - Rounding-mode constants (RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100).
  - add_step2_entry_t struct {sign, sum, zero, exp_max, frm}.
- Sub-module add_step2_mag: combinational sign-magnitude adder producing sign, sum and zero; instantiated once ahead of the FIFO.

Test Plan:
- Same-sign add: frac_shifted = frac_not_shifted = 26'h2000000, both signs 0, exp_max = 8'd127 -> one cycle later out_valid = 1, sum_out = 27'h4000000, carry_out = 1, sign_out = 0, exp_max_out = 127.
- Subtraction: sign_shifted = 1, frac_shifted = 26'h1000000, sign_not_shifted = 0, frac_not_shifted = 26'h2000000 -> sum_out = 27'h1000000, sign_out = 0, carry_out = 0.
- Exact cancel: both fractions 26'h2400000, opposite signs.
  - frm_in = 3'b010 -> sum_out = 0, zero_out = 1, sign_out = 1.
  - Repeat with frm_in = 3'b000 -> sign_out = 0.
- Backpressure: out_ready = 0, in_valid held for 3 cycles (DEPTH = 2) -> exactly 2 accepted, in_ready = 0 on the third cycle; raise out_ready -> results drain in order, in_ready returns 1 the cycle after the first pop.
- Streaming: out_ready = 1, 10 back-to-back operations -> 10 results on consecutive cycles, 1-cycle latency, count never exceeds 1.
- Reset mid-operation: RST asserted with 2 entries buffered -> out_valid = 0 and all outputs 0 immediately, without waiting for a clock edge; after release in_ready = 1 and a new operation completes normally.
